// File: rtl/mano_control_sequencer_if.sv
// ---------------------------------------------------------------------------
// mano_control_sequencer_if
// Bundle that joins the Mano timing-and-control unit to the datapath it steps.
//   master : the sequencer. It samples IR and the status flags. It drives the
//            timing decode, the opcode latch and every register/memory/ALU control.
//   slave  : the datapath side, which has the opposite directions.
// Signals:
//   ir[15:0], dr_zero, ac_msb, ac_zero, e_in, start, irq   (datapath -> sequencer)
//   t[2**SC_WIDTH-1:0], d[7:0], i_flag, running, bus_sel[2:0],
//   ar_ld/inr/clr, pc_ld/inr/clr, dr_ld, dr_inr, ir_ld, tr_ld,
//   mem_rd, mem_wr, alu_op[3:0]                            (sequencer -> datapath)
// ---------------------------------------------------------------------------
interface mano_control_sequencer_if #(
    parameter int SC_WIDTH = 4
);
    logic [15:0]             ir;
    logic                    dr_zero;
    logic                    ac_msb;
    logic                    ac_zero;
    logic                    e_in;
    logic                    start;
    logic                    irq;

    logic [2**SC_WIDTH-1:0]  t;
    logic [7:0]              d;
    logic                    i_flag;
    logic                    running;
    logic [2:0]              bus_sel;
    logic                    ar_ld, ar_inr, ar_clr;
    logic                    pc_ld, pc_inr, pc_clr;
    logic                    dr_ld, dr_inr, ir_ld, tr_ld;
    logic                    mem_rd, mem_wr;
    logic [3:0]              alu_op;

    modport master (
        input  ir, dr_zero, ac_msb, ac_zero, e_in, start, irq,
        output t, d, i_flag, running, bus_sel,
               ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr,
               dr_ld, dr_inr, ir_ld, tr_ld, mem_rd, mem_wr, alu_op
    );

    modport slave (
        output ir, dr_zero, ac_msb, ac_zero, e_in, start, irq,
        input  t, d, i_flag, running, bus_sel,
               ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr,
               dr_ld, dr_inr, ir_ld, tr_ld, mem_rd, mem_wr, alu_op
    );
endinterface

// File: rtl/mano_control_sequencer.sv
// ---------------------------------------------------------------------------
// mano_control_sequencer
// Timing-and-control unit for the Mano basic computer. It holds the sequence
// counter SC, the D0..D7 opcode latch, the I flip-flop and the start/stop flip-flop S.
// Every control output is decoded combinationally from that state plus IR and the
// status flags. This steps the datapath through fetch, decode, indirect and execute.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : mano_control_sequencer_if.master (IR/status in, controls out)
// Optional build macro INTERRUPT_EN adds the IEN and R flip-flops, the
// interrupt cycle RT0..RT2, and ION/IOF. Without it, irq is ignored.
// ---------------------------------------------------------------------------
module mano_control_sequencer #(
    parameter int SC_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    mano_control_sequencer_if.master bus
);
    localparam int TW = 2**SC_WIDTH;

    localparam logic [SC_WIDTH-1:0] SC_T0 = SC_WIDTH'(0);
    localparam logic [SC_WIDTH-1:0] SC_T1 = SC_WIDTH'(1);
    localparam logic [SC_WIDTH-1:0] SC_T2 = SC_WIDTH'(2);
    localparam logic [SC_WIDTH-1:0] SC_T3 = SC_WIDTH'(3);
    localparam logic [SC_WIDTH-1:0] SC_T4 = SC_WIDTH'(4);
    localparam logic [SC_WIDTH-1:0] SC_T5 = SC_WIDTH'(5);
    localparam logic [SC_WIDTH-1:0] SC_T6 = SC_WIDTH'(6);

    localparam logic [2:0] BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3,
                           BUS_AC   = 3'd4, BUS_IR = 3'd5, BUS_TR = 3'd6, BUS_MEM = 3'd7;

    localparam logic [3:0] ALU_NOP = 4'd0, ALU_AND = 4'd1, ALU_ADD = 4'd2, ALU_LDA = 4'd3,
                           ALU_CLA = 4'd4, ALU_CLE = 4'd5, ALU_CMA = 4'd6, ALU_CME = 4'd7,
                           ALU_CIR = 4'd8, ALU_CIL = 4'd9, ALU_INC = 4'd10;

    logic [SC_WIDTH-1:0] r_sc;
    logic [7:0]          r_d;
    logic                r_i;
    logic                r_s;

    logic       w_active;
    logic       w_int_cycle;
    logic       w_clr_sc;
    logic       w_halt;
    logic [2:0] w_bus;
    logic [3:0] w_alu;
    logic       w_ar_ld, w_ar_inr, w_ar_clr, w_pc_ld, w_pc_inr, w_pc_clr;
    logic       w_dr_ld, w_dr_inr, w_ir_ld, w_tr_ld, w_mem_rd, w_mem_wr;

`ifdef INTERRUPT_EN
    logic r_ien;
    logic r_r;
    logic w_ion, w_iof, w_rt_done, w_int_set;

    // R only replaces the three fetch slots; T3 onward is a normal instruction.
    assign w_int_cycle = r_r & ((r_sc == SC_T0) | (r_sc == SC_T1) | (r_sc == SC_T2));
    assign w_int_set   = r_s & r_ien & bus.irq &
                         ~((r_sc == SC_T0) | (r_sc == SC_T1) | (r_sc == SC_T2));
`else
    assign w_int_cycle = 1'b0;
`endif

    // The reset term makes all controls go quiet as soon as reset rises,
    // even though SC=0 would otherwise decode as T0.
    assign w_active = r_s & ~reset;

    always_comb begin
        w_bus    = BUS_NONE;
        w_alu    = ALU_NOP;
        w_ar_ld  = 1'b0; w_ar_inr = 1'b0; w_ar_clr = 1'b0;
        w_pc_ld  = 1'b0; w_pc_inr = 1'b0; w_pc_clr = 1'b0;
        w_dr_ld  = 1'b0; w_dr_inr = 1'b0; w_ir_ld  = 1'b0; w_tr_ld = 1'b0;
        w_mem_rd = 1'b0; w_mem_wr = 1'b0;
        w_clr_sc = 1'b0;
        w_halt   = 1'b0;
`ifdef INTERRUPT_EN
        w_ion     = 1'b0;
        w_iof     = 1'b0;
        w_rt_done = 1'b0;
`endif
        if (w_active) begin
            if (w_int_cycle) begin
                // Interrupt cycle: save PC at address 0, then continue at address 1.
                case (r_sc)
                    SC_T0:   begin w_ar_clr = 1'b1; w_bus = BUS_PC; w_tr_ld = 1'b1; end
                    SC_T1:   begin w_bus = BUS_TR; w_mem_wr = 1'b1; w_pc_clr = 1'b1; end
                    default: begin
                        w_pc_inr = 1'b1;
                        w_clr_sc = 1'b1;
`ifdef INTERRUPT_EN
                        w_rt_done = 1'b1;
`endif
                    end
                endcase
            end else begin
                case (r_sc)
                    SC_T0: begin w_bus = BUS_PC; w_ar_ld = 1'b1; end
                    SC_T1: begin w_mem_rd = 1'b1; w_bus = BUS_MEM; w_ir_ld = 1'b1; w_pc_inr = 1'b1; end
                    SC_T2: begin w_bus = BUS_IR; w_ar_ld = 1'b1; end
                    SC_T3: begin
                        if (!r_d[7]) begin
                            if (r_i) begin w_mem_rd = 1'b1; w_bus = BUS_MEM; w_ar_ld = 1'b1; end
                        end else if (!r_i) begin
                            w_clr_sc = 1'b1;
                            if      (bus.ir[11]) w_alu = ALU_CLA;
                            else if (bus.ir[10]) w_alu = ALU_CLE;
                            else if (bus.ir[9])  w_alu = ALU_CMA;
                            else if (bus.ir[8])  w_alu = ALU_CME;
                            else if (bus.ir[7])  w_alu = ALU_CIR;
                            else if (bus.ir[6])  w_alu = ALU_CIL;
                            else if (bus.ir[5])  w_alu = ALU_INC;
                            // SPA / SNA / SZA / SZE skip tests, OR-ed when combined
                            w_pc_inr = (bus.ir[4] & ~bus.ac_msb) | (bus.ir[3] & bus.ac_msb) |
                                       (bus.ir[2] & bus.ac_zero) | (bus.ir[1] & ~bus.e_in);
                            w_halt   = bus.ir[0];
                        end else begin
                            w_clr_sc = 1'b1;
`ifdef INTERRUPT_EN
                            w_ion = (bus.ir == 16'hF080);
                            w_iof = (bus.ir == 16'hF040);
`endif
                        end
                    end
                    SC_T4: begin
                        if (r_d[0] | r_d[1] | r_d[2] | r_d[6]) begin
                            w_mem_rd = 1'b1; w_bus = BUS_MEM; w_dr_ld = 1'b1;
                        end
                        if (r_d[3]) begin w_bus = BUS_AC; w_mem_wr = 1'b1; w_clr_sc = 1'b1; end
                        if (r_d[4]) begin w_bus = BUS_AR; w_pc_ld = 1'b1; w_clr_sc = 1'b1; end
                        if (r_d[5]) begin w_bus = BUS_PC; w_mem_wr = 1'b1; w_ar_inr = 1'b1; end
                    end
                    SC_T5: begin
                        if (r_d[0]) begin w_alu = ALU_AND; w_clr_sc = 1'b1; end
                        if (r_d[1]) begin w_alu = ALU_ADD; w_clr_sc = 1'b1; end
                        if (r_d[2]) begin w_alu = ALU_LDA; w_clr_sc = 1'b1; end
                        if (r_d[5]) begin w_bus = BUS_AR; w_pc_ld = 1'b1; w_clr_sc = 1'b1; end
                        if (r_d[6]) w_dr_inr = 1'b1;
                    end
                    SC_T6: begin
                        if (r_d[6]) begin
                            w_bus = BUS_DR; w_mem_wr = 1'b1; w_pc_inr = bus.dr_zero; w_clr_sc = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sc <= '0;
            r_d  <= '0;
            r_i  <= 1'b0;
            r_s  <= 1'b1;
`ifdef INTERRUPT_EN
            r_ien <= 1'b0;
            r_r   <= 1'b0;
`endif
        end else if (r_s) begin
            r_sc <= w_clr_sc ? '0 : r_sc + SC_WIDTH'(1);
            if (w_halt) r_s <= 1'b0;
            // The opcode is latched only at the end of a real fetch, not during RT2.
            if ((r_sc == SC_T2) && !w_int_cycle) begin
                r_d <= 8'(1) << bus.ir[14:12];
                r_i <= bus.ir[15];
            end
`ifdef INTERRUPT_EN
            if (w_int_set) r_r <= 1'b1;
            if (w_ion)     r_ien <= 1'b1;
            if (w_iof)     r_ien <= 1'b0;
            if (w_rt_done) begin
                r_ien <= 1'b0;
                r_r   <= 1'b0;
            end
`endif
        end else begin
            // Halted: SC stays parked at T0 until restarted.
            r_sc <= '0;
            if (bus.start) r_s <= 1'b1;
        end
    end

    assign bus.t       = TW'(1) << r_sc;
    assign bus.d       = r_d;
    assign bus.i_flag  = r_i;
    assign bus.running = r_s;
    assign bus.bus_sel = w_bus;
    assign bus.alu_op  = w_alu;
    assign bus.ar_ld   = w_ar_ld;
    assign bus.ar_inr  = w_ar_inr;
    assign bus.ar_clr  = w_ar_clr;
    assign bus.pc_ld   = w_pc_ld;
    assign bus.pc_inr  = w_pc_inr;
    assign bus.pc_clr  = w_pc_clr;
    assign bus.dr_ld   = w_dr_ld;
    assign bus.dr_inr  = w_dr_inr;
    assign bus.ir_ld   = w_ir_ld;
    assign bus.tr_ld   = w_tr_ld;
    assign bus.mem_rd  = w_mem_rd;
    assign bus.mem_wr  = w_mem_wr;
endmodule

// File: tb/tb_mano_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mano_control_sequencer
// Directed instruction sequences for the Mano control sequencer. Each cycle, the
// stimulus pushes the hand-derived control word it expects. A separate monitor
// pops that word and compares it with the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_mano_control_sequencer;
    typedef struct packed {
        logic [15:0] t;
        logic [7:0]  d;
        logic        i;
        logic        run;
        logic [2:0]  bsel;
        logic [11:0] ctl;
        logic [3:0]  alu;
    } obs_t;

    // ctl bit order: ar_ld ar_inr ar_clr pc_ld pc_inr pc_clr dr_ld dr_inr ir_ld tr_ld mem_rd mem_wr
    localparam logic [11:0] AR_LD  = 12'h800, AR_INR = 12'h400, AR_CLR = 12'h200;
    localparam logic [11:0] PC_LD  = 12'h100, PC_INR = 12'h080, PC_CLR = 12'h040;
    localparam logic [11:0] DR_LD  = 12'h020, DR_INR = 12'h010, IR_LD  = 12'h008;
    localparam logic [11:0] TR_LD  = 12'h004, MEM_RD = 12'h002, MEM_WR = 12'h001;
    localparam logic [11:0] NONE   = 12'h000;

    logic clk;
    logic reset;

    mano_control_sequencer_if #(.SC_WIDTH(4)) sif ();

    mano_control_sequencer #(.SC_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string nm_q[$];
    int    total = 0;
    int    bad   = 0;

    // Drive values and expected sequencer state, set by the stimulus before each step.
    logic       drv_rst   = 1'b1;
    logic [3:0] drv_st    = 4'b0000;   // {dr_zero, ac_msb, ac_zero, e_in}
    logic       drv_start = 1'b0;
    logic       drv_irq   = 1'b0;
    logic [7:0] xd        = 8'h00;
    logic       xi        = 1'b0;
    logic       xrun      = 1'b1;

    function automatic obs_t sample();
        obs_t a;
        a.t    = sif.t;
        a.d    = sif.d;
        a.i    = sif.i_flag;
        a.run  = sif.running;
        a.bsel = sif.bus_sel;
        a.ctl  = {sif.ar_ld, sif.ar_inr, sif.ar_clr, sif.pc_ld, sif.pc_inr, sif.pc_clr,
                  sif.dr_ld, sif.dr_inr, sif.ir_ld, sif.tr_ld, sif.mem_rd, sif.mem_wr};
        a.alu  = sif.alu_op;
        return a;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e;
            obs_t  a;
            string n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            a = sample();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got t=%h d=%h i=%b run=%b bus=%0d ctl=%h alu=%0d, want t=%h d=%h i=%b run=%b bus=%0d ctl=%h alu=%0d",
                         n, a.t, a.d, a.i, a.run, a.bsel, a.ctl, a.alu,
                         e.t, e.d, e.i, e.run, e.bsel, e.ctl, e.alu);
            end
        end
    end

    task automatic step(input string nm, input logic [15:0] irv, input int tix,
                        input logic [2:0] bsel, input logic [11:0] ctl, input logic [3:0] alu);
        obs_t e;
        @(posedge clk);
        #1;
        reset       = drv_rst;
        sif.ir      = irv;
        sif.dr_zero = drv_st[3];
        sif.ac_msb  = drv_st[2];
        sif.ac_zero = drv_st[1];
        sif.e_in    = drv_st[0];
        sif.start   = drv_start;
        sif.irq     = drv_irq;
        e.t    = 16'(1) << tix;
        e.d    = xd;
        e.i    = xi;
        e.run  = xrun;
        e.bsel = bsel;
        e.ctl  = ctl;
        e.alu  = alu;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic fetch(input string nm, input logic [15:0] irv);
        step({nm, " T0"}, irv, 0, 3'd2, AR_LD, 4'd0);
        step({nm, " T1"}, irv, 1, 3'd7, MEM_RD | IR_LD | PC_INR, 4'd0);
        step({nm, " T2"}, irv, 2, 3'd5, AR_LD, 4'd0);
    endtask

    task automatic regref(input string nm, input logic [15:0] irv, input logic [3:0] st,
                          input logic [11:0] ctl, input logic [3:0] alu);
        fetch(nm, irv);
        xd = 8'h80; xi = 1'b0; drv_st = st;
        step({nm, " T3"}, irv, 3, 3'd0, ctl, alu);
        drv_st = 4'b0000;
    endtask

    initial begin
        reset = 1'b1;
        sif.ir = 16'h0000; sif.dr_zero = 1'b0; sif.ac_msb = 1'b0; sif.ac_zero = 1'b0;
        sif.e_in = 1'b0; sif.start = 1'b0; sif.irq = 1'b0;

        // Reset state: T0 shown, running, all controls quiet.
        step("reset0", 16'h0000, 0, 3'd0, NONE, 4'd0);
        step("reset1", 16'h0000, 0, 3'd0, NONE, 4'd0);
        drv_rst = 1'b0;

        // LDA direct
        fetch("lda", 16'h2123);
        xd = 8'h04; xi = 1'b0;
        step("lda T3", 16'h2123, 3, 3'd0, NONE, 4'd0);
        step("lda T4", 16'h2123, 4, 3'd7, MEM_RD | DR_LD, 4'd0);
        step("lda T5", 16'h2123, 5, 3'd0, NONE, 4'd3);

        // ADD indirect
        fetch("add_i", 16'h9050);
        xd = 8'h02; xi = 1'b1;
        step("add_i T3", 16'h9050, 3, 3'd7, MEM_RD | AR_LD, 4'd0);
        step("add_i T4", 16'h9050, 4, 3'd7, MEM_RD | DR_LD, 4'd0);
        step("add_i T5", 16'h9050, 5, 3'd0, NONE, 4'd2);

        // ISZ with DR reaching zero, then with DR non-zero
        for (int k = 0; k < 2; k++) begin
            fetch("isz", 16'h6010);
            xd = 8'h40; xi = 1'b0;
            step("isz T3", 16'h6010, 3, 3'd0, NONE, 4'd0);
            step("isz T4", 16'h6010, 4, 3'd7, MEM_RD | DR_LD, 4'd0);
            step("isz T5", 16'h6010, 5, 3'd0, DR_INR, 4'd0);
            drv_st = (k == 0) ? 4'b1000 : 4'b0000;
            step((k == 0) ? "isz T6 dz1" : "isz T6 dz0", 16'h6010, 6, 3'd3,
                 (k == 0) ? (MEM_WR | PC_INR) : MEM_WR, 4'd0);
            drv_st = 4'b0000;
        end

        // STA, BUN, BSA
        fetch("sta", 16'h3000);
        xd = 8'h08;
        step("sta T3", 16'h3000, 3, 3'd0, NONE, 4'd0);
        step("sta T4", 16'h3000, 4, 3'd4, MEM_WR, 4'd0);
        fetch("bun", 16'h4123);
        xd = 8'h10;
        step("bun T3", 16'h4123, 3, 3'd0, NONE, 4'd0);
        step("bun T4", 16'h4123, 4, 3'd1, PC_LD, 4'd0);
        fetch("bsa", 16'h5000);
        xd = 8'h20;
        step("bsa T3", 16'h5000, 3, 3'd0, NONE, 4'd0);
        step("bsa T4", 16'h5000, 4, 3'd2, MEM_WR | AR_INR, 4'd0);
        step("bsa T5", 16'h5000, 5, 3'd1, PC_LD, 4'd0);

        // Register reference: ALU priority and skip conditions
        regref("cla",     16'h7800, 4'b0000, NONE,   4'd4);
        regref("cla_cle", 16'h7C00, 4'b0000, NONE,   4'd4);
        regref("inc",     16'h7020, 4'b0000, NONE,   4'd10);
        regref("spa",     16'h7010, 4'b0000, PC_INR, 4'd0);
        regref("sna",     16'h7008, 4'b0000, NONE,   4'd0);
        regref("sza",     16'h7004, 4'b0010, PC_INR, 4'd0);
        regref("sze",     16'h7002, 4'b0001, NONE,   4'd0);

        // I/O: IOF then ION; no controls asserted either way
        fetch("iof", 16'hF040);
        xd = 8'h80; xi = 1'b1;
        step("iof T3", 16'hF040, 3, 3'd0, NONE, 4'd0);
        fetch("ion", 16'hF080);
        step("ion T3", 16'hF080, 3, 3'd0, NONE, 4'd0);

`ifdef INTERRUPT_EN
        // IEN=1 and irq during BUN T4 -> interrupt cycle replaces the next fetch
        fetch("bun_int", 16'h4123);
        xd = 8'h10; xi = 1'b0;
        step("bun_int T3", 16'h4123, 3, 3'd0, NONE, 4'd0);
        drv_irq = 1'b1;
        step("bun_int T4", 16'h4123, 4, 3'd1, PC_LD, 4'd0);
        drv_irq = 1'b0;
        step("RT0", 16'h4123, 0, 3'd2, AR_CLR | TR_LD, 4'd0);
        step("RT1", 16'h4123, 1, 3'd6, MEM_WR | PC_CLR, 4'd0);
        step("RT2", 16'h4123, 2, 3'd0, PC_INR, 4'd0);
        // IEN is now clear, so irq held high must not start another interrupt cycle.
        drv_irq = 1'b1;
        fetch("sta_noint", 16'h3000);
        xd = 8'h08;
        step("sta_noint T3", 16'h3000, 3, 3'd0, NONE, 4'd0);
        step("sta_noint T4", 16'h3000, 4, 3'd4, MEM_WR, 4'd0);
        drv_irq = 1'b0;
`endif

        // HLT: halted for 20 cycles, then a start pulse restarts at T0
        fetch("hlt", 16'h7001);
        xd = 8'h80; xi = 1'b0;
        step("hlt T3", 16'h7001, 3, 3'd0, NONE, 4'd0);
        xrun = 1'b0;
        for (int k = 0; k < 20; k++) step("halted", 16'h7001, 0, 3'd0, NONE, 4'd0);
        drv_start = 1'b1;
        step("start pulse", 16'h7001, 0, 3'd0, NONE, 4'd0);
        drv_start = 1'b0;
        xrun = 1'b1;

        // LDA restarted after the halt, with reset asserted mid-T5
        fetch("lda2", 16'h2123);
        xd = 8'h04; xi = 1'b0;
        step("lda2 T3", 16'h2123, 3, 3'd0, NONE, 4'd0);
        step("lda2 T4", 16'h2123, 4, 3'd7, MEM_RD | DR_LD, 4'd0);
        drv_rst = 1'b1;
        xd = 8'h00;
        step("reset mid T5", 16'h2123, 0, 3'd0, NONE, 4'd0);
        drv_rst = 1'b0;
        step("post-reset T0", 16'h2123, 0, 3'd2, AR_LD, 4'd0);
        step("post-reset T1", 16'h2123, 1, 3'd7, MEM_RD | IR_LD | PC_INR, 4'd0);

        begin
            int waited;
            waited = 0;
            while (exp_q.size() > 0 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            #1;
            if (exp_q.size() > 0) begin
                total++;
                bad++;
                $display("FAIL drain: got %0d pending, want 0", exp_q.size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
